seq_fc_layer: RTL and testbench

Parametrised, time-multiplexed fully-connected layer for the generated network pipeline. It is the successor to the fixed-size single-MAC linear layers and adds:
- generic input and output counts;
- signed arithmetic with a wide accumulator;
- requantisation with rounding and saturation;
- a runtime-loadable weight/bias store;
- a start/busy/done handshake.

One MAC is shared across all neurons. Layers chain by connecting one layer's `done` and `out_vec` to the next layer's `start` and `in_vec`.

---
 rtl/seq_fc_layer.sv | 212 +++++++++++++++++++++
 tb/tb_seq_fc_layer.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_fc_layer.sv
// rtl/seq_fc_layer.sv - time-multiplexed fully-connected layer, one shared MAC
// Optional build macro: SEQ_FC_FUSED_RELU_EN (clamps negative outputs to zero in writeback)
module seq_fc_layer #(
  parameter int N_IN   = 4,
  parameter int N_OUT  = 4,
  parameter int DW     = 8,
  parameter int BW     = 16,
  parameter int ACC_W  = 24,
  parameter int SHIFT  = 7,
  parameter int OW     = 8,
  parameter int ADDR_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [N_IN*DW-1:0]    in_vec,
  output logic                  busy,
  output logic                  done,
  output logic [N_OUT*OW-1:0]   out_vec,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [BW-1:0]         wr_data
);

  localparam int NW = N_IN * N_OUT;
  localparam int IW = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int JW = (N_OUT > 1) ? $clog2(N_OUT) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_WB   = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  // Half-LSB rounding constant; zero when no shift is applied.
  localparam int RND_INT = (SHIFT > 0) ? (1 << ((SHIFT > 0) ? SHIFT - 1 : 0)) : 0;
  localparam logic signed [ACC_W:0] C_RND = (ACC_W+1)'(RND_INT);
  localparam logic signed [ACC_W:0] C_MAX = {{(ACC_W+2-OW){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [ACC_W:0] C_MIN = {{(ACC_W+2-OW){1'b1}}, {(OW-1){1'b0}}};

  logic [1:0]              r_state;
  logic signed [DW-1:0]    r_w [NW];
  logic signed [BW-1:0]    r_b [N_OUT];
  logic [N_IN*DW-1:0]      r_x;
  logic [IW-1:0]           r_i;
  logic [JW-1:0]           r_j;
  logic signed [ACC_W-1:0] r_acc;
  logic [N_OUT*OW-1:0]     r_s;
  logic [N_OUT*OW-1:0]     r_out;

  logic                    w_idle;
  logic [31:0]             w_addr;
  logic signed [DW-1:0]    w_x_sel;
  logic signed [DW-1:0]    w_w_sel;
  logic signed [2*DW-1:0]  w_prod;
  logic signed [BW-1:0]    w_b0;
  logic signed [BW-1:0]    w_b_nxt;
  logic signed [ACC_W:0]   w_acc_ext;
  logic signed [ACC_W:0]   w_rnd;
  logic signed [ACC_W:0]   w_shr;
  logic signed [OW-1:0]    w_sat;
  logic signed [OW-1:0]    w_q;
  logic [N_OUT*OW-1:0]     w_s_next;
  logic                    w_i_last;
  logic                    w_j_last;

  assign w_idle   = (r_state == S_IDLE);
  assign w_addr   = 32'(wr_addr);
  assign w_i_last = (r_i == IW'(N_IN - 1));
  assign w_j_last = (r_j == JW'(N_OUT - 1));

  assign busy    = (r_state != S_IDLE);
  assign done    = (r_state == S_DONE);
  assign out_vec = r_out;

  // A bias[0] write in the accepting cycle must be seen by the accumulator preload.
  assign w_b0 = (wr_en && (w_addr == 32'(NW))) ? wr_data : r_b[0];

  // Operand muxes: pick x[i] and w[j][i] for the current MAC step.
  always_comb begin
    w_x_sel = '0;
    w_w_sel = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (r_i == IW'(i)) begin
        w_x_sel = r_x[i*DW +: DW];
      end
    end
    for (int j = 0; j < N_OUT; j++) begin
      for (int i = 0; i < N_IN; i++) begin
        if ((r_j == JW'(j)) && (r_i == IW'(i))) begin
          w_w_sel = r_w[j*N_IN + i];
        end
      end
    end
  end

  // Bias of the next neuron, used to preload the accumulator when leaving WB.
  always_comb begin
    w_b_nxt = '0;
    for (int j = 0; j < N_OUT - 1; j++) begin
      if (r_j == JW'(j)) begin
        w_b_nxt = r_b[j+1];
      end
    end
  end

  assign w_prod    = w_x_sel * w_w_sel;
  assign w_acc_ext = {r_acc[ACC_W-1], r_acc};
  assign w_rnd     = w_acc_ext + C_RND;
  assign w_shr     = w_rnd >>> SHIFT;

  // Requantise: round-half-up shift, then clamp into the signed output range.
  always_comb begin
    if (w_shr > C_MAX) begin
      w_sat = C_MAX[OW-1:0];
    end else if (w_shr < C_MIN) begin
      w_sat = C_MIN[OW-1:0];
    end else begin
      w_sat = w_shr[OW-1:0];
    end
`ifdef SEQ_FC_FUSED_RELU_EN
    w_q = w_sat[OW-1] ? '0 : w_sat;
`else
    w_q = w_sat;
`endif
  end

  // Staging vector with the current neuron's result slotted in.
  always_comb begin
    w_s_next = r_s;
    for (int j = 0; j < N_OUT; j++) begin
      if (r_j == JW'(j)) begin
        w_s_next[j*OW +: OW] = w_q;
      end
    end
  end

  // Parameter store: writes land only while idle; out-of-range addresses are ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NW; k++) begin
        r_w[k] <= '0;
      end
      for (int j = 0; j < N_OUT; j++) begin
        r_b[j] <= '0;
      end
    end else if (wr_en && w_idle) begin
      for (int k = 0; k < NW; k++) begin
        if (w_addr == 32'(k)) begin
          r_w[k] <= wr_data[DW-1:0];
        end
      end
      for (int j = 0; j < N_OUT; j++) begin
        if (w_addr == 32'(NW + j)) begin
          r_b[j] <= wr_data;
        end
      end
    end
  end

  // Sequencer: accept, N_IN MAC cycles plus one writeback per neuron, then a done cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_x     <= '0;
      r_i     <= '0;
      r_j     <= '0;
      r_acc   <= '0;
      r_s     <= '0;
      r_out   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_x     <= in_vec;
            r_i     <= '0;
            r_j     <= '0;
            r_acc   <= ACC_W'(w_b0);
            r_state <= S_CALC;
          end
        end
        S_CALC: begin
          r_acc <= r_acc + ACC_W'(w_prod);
          if (w_i_last) begin
            r_state <= S_WB;
          end else begin
            r_i <= r_i + IW'(1);
          end
        end
        S_WB: begin
          r_s <= w_s_next;
          if (w_j_last) begin
            // Publish every output in one edge so out_vec is valid during done.
            r_out   <= w_s_next;
            r_state <= S_DONE;
          end else begin
            r_j     <= r_j + JW'(1);
            r_i     <= '0;
            r_acc   <= ACC_W'(w_b_nxt);
            r_state <= S_CALC;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_fc_layer.sv
// tb/tb_seq_fc_layer.sv - self-checking bench for seq_fc_layer
module tb_seq_fc_layer;

  localparam int N_IN   = 4;
  localparam int N_OUT  = 4;
  localparam int DW     = 8;
  localparam int BW     = 16;
  localparam int ACC_W  = 24;
  localparam int SHIFT  = 7;
  localparam int OW     = 8;
  localparam int ADDR_W = 8;
  localparam int LAT    = N_OUT * (N_IN + 1);
  localparam int BBASE  = N_IN * N_OUT;

  logic                  clk;
  logic                  rst;
  logic                  start;
  logic [N_IN*DW-1:0]    in_vec;
  logic                  busy;
  logic                  done;
  logic [N_OUT*OW-1:0]   out_vec;
  logic                  wr_en;
  logic [ADDR_W-1:0]     wr_addr;
  logic [BW-1:0]         wr_data;

  seq_fc_layer #(
    .N_IN(N_IN), .N_OUT(N_OUT), .DW(DW), .BW(BW), .ACC_W(ACC_W),
    .SHIFT(SHIFT), .OW(OW), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .in_vec(in_vec),
    .busy(busy), .done(done), .out_vec(out_vec),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total;
  int bad;

  int m_w [N_OUT][N_IN];
  int m_b [N_OUT];
  int m_x [N_IN];

  typedef struct {
    string name;
    int    x;
    int    w_row [N_OUT];
    int    b     [N_OUT];
    int    y     [N_OUT];
  } vec_t;

  vec_t tbl [3];

  function automatic vec_t mk(string nm, int x,
                              int w0, int w1, int w2, int w3,
                              int b0, int b1, int b2, int b3,
                              int y0, int y1, int y2, int y3);
    vec_t v;
    v.name = nm; v.x = x;
    v.w_row[0] = w0; v.w_row[1] = w1; v.w_row[2] = w2; v.w_row[3] = w3;
    v.b[0] = b0; v.b[1] = b1; v.b[2] = b2; v.b[3] = b3;
    v.y[0] = y0; v.y[1] = y1; v.y[2] = y2; v.y[3] = y3;
    return v;
  endfunction

  // Reference: dot product plus bias, divide by 2^SHIFT rounding half up, clamp.
  function automatic int ref_y(int j);
    longint acc;
    longint q;
    acc = longint'(m_b[j]);
    for (int i = 0; i < N_IN; i++) acc += longint'(m_x[i]) * longint'(m_w[j][i]);
    acc += (SHIFT > 0) ? (longint'(1) << (SHIFT - 1)) : 0;
    q = acc / (longint'(1) << SHIFT);
    if ((q * (longint'(1) << SHIFT)) > acc) q = q - 1;
    if (q > 127) q = 127;
    if (q < -128) q = -128;
`ifdef SEQ_FC_FUSED_RELU_EN
    if (q < 0) q = 0;
`endif
    return int'(q);
  endfunction

  function automatic int y_out(int j);
    logic signed [OW-1:0] v;
    v = out_vec[j*OW +: OW];
    return int'(v);
  endfunction

  task automatic chk(string nm, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic wr(input int addr, input int data);
    @(posedge clk); #1;
    wr_en = 1'b1; wr_addr = ADDR_W'(addr); wr_data = BW'(data);
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic load_params();
    for (int j = 0; j < N_OUT; j++)
      for (int i = 0; i < N_IN; i++) wr(j*N_IN + i, m_w[j][i]);
    for (int j = 0; j < N_OUT; j++) wr(BBASE + j, m_b[j]);
  endtask

  task automatic drive_x();
    for (int i = 0; i < N_IN; i++) in_vec[i*DW +: DW] = DW'(m_x[i]);
  endtask

  task automatic randomize_model();
    for (int j = 0; j < N_OUT; j++) begin
      for (int i = 0; i < N_IN; i++) m_w[j][i] = int'($urandom_range(255)) - 128;
      m_b[j] = int'($urandom_range(65535)) - 32768;
    end
    for (int i = 0; i < N_IN; i++) m_x[i] = int'($urandom_range(255)) - 128;
  endtask

  // Start one run (optionally with a same-cycle parameter write) and wait for done.
  task automatic do_run(input bit co_wr, input int a, input int d, output int lat);
    @(posedge clk); #1;
    start = 1'b1; wr_en = co_wr; wr_addr = ADDR_W'(a); wr_data = BW'(d);
    @(posedge clk); #1;
    start = 1'b0; wr_en = 1'b0;
    lat = -1;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic check_outputs(string nm);
    for (int j = 0; j < N_OUT; j++) chk($sformatf("%s y%0d", nm, j), y_out(j), ref_y(j));
  endtask

  initial begin
    int lat;
    int y1 [N_OUT];
    int y2 [N_OUT];
    int dq [$];
    int cnt;

    total = 0; bad = 0;
    rst = 1'b1; start = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; in_vec = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    chk("reset busy", int'(busy), 0);
    chk("reset done", int'(done), 0);
    chk("reset out_vec", int'(out_vec), 0);

    tbl[0] = mk("basic", 2, 64, 64, 64, 64, 0, 0, 0, 0, 4, 4, 4, 4);
`ifdef SEQ_FC_FUSED_RELU_EN
    tbl[1] = mk("saturate", 127, 127, -128, 0, 0, 0, 0, 0, 0, 127, 0, 0, 0);
    tbl[2] = mk("rounding", 5, 0, 0, 0, 0, 64, 63, -65, -64, 1, 0, 0, 0);
`else
    tbl[1] = mk("saturate", 127, 127, -128, 0, 0, 0, 0, 0, 0, 127, -128, 0, 0);
    tbl[2] = mk("rounding", 5, 0, 0, 0, 0, 64, 63, -65, -64, 1, 0, -1, 0);
`endif

    for (int t = 0; t < 3; t++) begin
      for (int j = 0; j < N_OUT; j++) begin
        for (int i = 0; i < N_IN; i++) m_w[j][i] = tbl[t].w_row[j];
        m_b[j] = tbl[t].b[j];
      end
      for (int i = 0; i < N_IN; i++) m_x[i] = tbl[t].x;
      load_params();
      drive_x();
      do_run(1'b0, 0, 0, lat);
      chk({tbl[t].name, " latency"}, lat, LAT);
      for (int j = 0; j < N_OUT; j++)
        chk($sformatf("%s y%0d", tbl[t].name, j), y_out(j), tbl[t].y[j]);
    end

    // Random parameters; stray out-of-range writes; bias[0] written in the start cycle.
    for (int r = 0; r < 6; r++) begin
      int nb0;
      randomize_model();
      load_params();
      wr(BBASE + N_OUT, 16'h1234);
      wr(255, 16'h7f7f);
      drive_x();
      nb0 = int'($urandom_range(65535)) - 32768;
      m_b[0] = nb0;
      do_run(1'b1, BBASE, nb0, lat);
      chk($sformatf("rand%0d latency", r), lat, LAT);
      check_outputs($sformatf("rand%0d", r));
    end

    // Handshake: start held, in_vec changed and weight write dropped mid-run.
    randomize_model();
    m_w[0][0] = 1;
    load_params();
    drive_x();
    for (int j = 0; j < N_OUT; j++) y1[j] = ref_y(j);
    @(posedge clk); #1;
    start = 1'b1;
    for (int e = 0; e < 60; e++) begin
      @(posedge clk); #1;
      if (e == 3) begin
        for (int i = 0; i < N_IN; i++) m_x[i] = int'($urandom_range(255)) - 128;
        drive_x();
        for (int j = 0; j < N_OUT; j++) y2[j] = ref_y(j);
      end
      if (e == 5) begin
        wr_en = 1'b1; wr_addr = '0; wr_data = 16'h0055;
      end
      if (e == 6) wr_en = 1'b0;
      if (e == 29) start = 1'b0;
      if (done) dq.push_back(e);
      if (e == LAT) begin
        chk("hs busy at done", int'(busy), 1);
        for (int j = 0; j < N_OUT; j++) chk($sformatf("hs run1 y%0d", j), y_out(j), y1[j]);
      end
      if (e == LAT + 1) chk("hs busy after done", int'(busy), 0);
      if (e == LAT + 2) chk("hs reaccept busy", int'(busy), 1);
      if (e == 2*LAT + 2)
        for (int j = 0; j < N_OUT; j++) chk($sformatf("hs run2 y%0d", j), y_out(j), y2[j]);
    end
    chk("hs done count", dq.size(), 2);
    chk("hs done1 edge", (dq.size() > 0) ? dq[0] : -1, LAT);
    chk("hs done2 edge", (dq.size() > 1) ? dq[1] : -1, 2*LAT + 2);

    // Reset mid-run aborts and clears parameters.
    randomize_model();
    load_params();
    drive_x();
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort busy", int'(busy), 0);
    chk("abort done", int'(done), 0);
    chk("abort out_vec", int'(out_vec), 0);
    cnt = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      if (done) cnt++;
    end
    chk("abort no done", cnt, 0);
    for (int j = 0; j < N_OUT; j++) begin
      for (int i = 0; i < N_IN; i++) m_w[j][i] = 0;
      m_b[j] = 0;
    end
    for (int i = 0; i < N_IN; i++) m_x[i] = int'($urandom_range(255)) - 128;
    drive_x();
    do_run(1'b0, 0, 0, lat);
    chk("cleared latency", lat, LAT);
    check_outputs("cleared");
    randomize_model();
    load_params();
    drive_x();
    do_run(1'b0, 0, 0, lat);
    chk("reload latency", lat, LAT);
    check_outputs("reload");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
